// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath widths, ALU op encodings and the pipeline bubble value.
package cpu_pkg;

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned RADDR_W = 5;
   localparam int unsigned CTRL_W  = 5;
   localparam int unsigned SHAMT_W = 5;

   localparam logic [CTRL_W-1:0] ALU_ADD = 5'd0;
   localparam logic [CTRL_W-1:0] ALU_SUB = 5'd1;
   localparam logic [CTRL_W-1:0] ALU_AND = 5'd2;
   localparam logic [CTRL_W-1:0] ALU_OR  = 5'd3;
   localparam logic [CTRL_W-1:0] ALU_XOR = 5'd4;
   localparam logic [CTRL_W-1:0] ALU_NOR = 5'd5;
   localparam logic [CTRL_W-1:0] ALU_SLL = 5'd6;
   localparam logic [CTRL_W-1:0] ALU_SRL = 5'd7;
   localparam logic [CTRL_W-1:0] ALU_SRA = 5'd8;
   localparam logic [CTRL_W-1:0] ALU_SLT = 5'd9;

   // A bubble is a non-writing ADD of zeros, so the ALU always sees a legal op.
   localparam logic [CTRL_W-1:0] BUBBLE_CTRL = ALU_ADD;
   localparam logic              BUBBLE_VALID = 1'b0;

endpackage

// File: rtl/fwd_mux.sv
// Per-source RAW bypass: picks the youngest in-flight write to addr, else the stored value.
module fwd_mux #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned RADDR_W = 5
) (
   input  logic [RADDR_W-1:0] addr,
   input  logic [DATA_W-1:0]  stored,
   input  logic               mem_we,
   input  logic [RADDR_W-1:0] mem_waddr,
   input  logic [DATA_W-1:0]  mem_wdata,
   input  logic               wb_we,
   input  logic [RADDR_W-1:0] wb_waddr,
   input  logic [DATA_W-1:0]  wb_wdata,
   output logic [DATA_W-1:0]  value
);

   // r0 is hardwired zero, so it is never bypassed; MEM is younger than WB and wins.
   always_comb begin
      value = stored;
      if (addr != '0) begin
         if (mem_we && (mem_waddr == addr)) begin
            value = mem_wdata;
         end else if (wb_we && (wb_waddr == addr)) begin
            value = wb_wdata;
         end
      end
   end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with EX-stage forwarding and ALU operand selection.
module ex_operand_stage #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned RADDR_W = 5,
   parameter int unsigned CTRL_W  = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               stall,
   input  logic               flush,
   input  logic               id_valid,
   input  logic [CTRL_W-1:0]  id_alu_ctrl,
   input  logic               id_sign,
   input  logic [RADDR_W-1:0] id_rs_addr,
   input  logic [RADDR_W-1:0] id_rt_addr,
   input  logic [DATA_W-1:0]  id_rs_data,
   input  logic [DATA_W-1:0]  id_rt_data,
   input  logic [DATA_W-1:0]  id_imm,
   input  logic [4:0]         id_shamt,
   input  logic               id_src1_shamt,
   input  logic               id_src2_imm,
   input  logic [RADDR_W-1:0] id_rd_addr,
   input  logic               id_reg_write,
   input  logic               mem_we,
   input  logic [RADDR_W-1:0] mem_waddr,
   input  logic [DATA_W-1:0]  mem_wdata,
   input  logic               wb_we,
   input  logic [RADDR_W-1:0] wb_waddr,
   input  logic [DATA_W-1:0]  wb_wdata,
   output logic               ex_valid,
   output logic [CTRL_W-1:0]  ex_alu_ctrl,
   output logic               ex_sign,
   output logic [DATA_W-1:0]  ex_in1,
   output logic [DATA_W-1:0]  ex_in2,
   output logic [DATA_W-1:0]  ex_store_data,
   output logic [RADDR_W-1:0] ex_rd_addr,
   output logic               ex_reg_write
);
   import cpu_pkg::*;

   logic               valid_q;
   logic [CTRL_W-1:0]  alu_ctrl_q;
   logic               sign_q;
   logic [RADDR_W-1:0] rs_addr_q;
   logic [RADDR_W-1:0] rt_addr_q;
   logic [DATA_W-1:0]  rs_data_q;
   logic [DATA_W-1:0]  rt_data_q;
   logic [DATA_W-1:0]  imm_q;
   logic [4:0]         shamt_q;
   logic               src1_shamt_q;
   logic               src2_imm_q;
   logic [RADDR_W-1:0] rd_addr_q;
   logic               reg_write_q;

   logic [DATA_W-1:0]  fwd_rs;
   logic [DATA_W-1:0]  fwd_rt;

   fwd_mux #(
      .DATA_W (DATA_W),
      .RADDR_W(RADDR_W)
   ) u_fwd_rs (
      .addr     (rs_addr_q),
      .stored   (rs_data_q),
      .mem_we   (mem_we),
      .mem_waddr(mem_waddr),
      .mem_wdata(mem_wdata),
      .wb_we    (wb_we),
      .wb_waddr (wb_waddr),
      .wb_wdata (wb_wdata),
      .value    (fwd_rs)
   );

   fwd_mux #(
      .DATA_W (DATA_W),
      .RADDR_W(RADDR_W)
   ) u_fwd_rt (
      .addr     (rt_addr_q),
      .stored   (rt_data_q),
      .mem_we   (mem_we),
      .mem_waddr(mem_waddr),
      .mem_wdata(mem_wdata),
      .wb_we    (wb_we),
      .wb_waddr (wb_waddr),
      .wb_wdata (wb_wdata),
      .value    (fwd_rt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n || flush) begin
         // Reset and flush both leave a bubble behind.
         valid_q      <= BUBBLE_VALID;
         alu_ctrl_q   <= CTRL_W'(BUBBLE_CTRL);
         sign_q       <= 1'b0;
         rs_addr_q    <= '0;
         rt_addr_q    <= '0;
         rs_data_q    <= '0;
         rt_data_q    <= '0;
         imm_q        <= '0;
         shamt_q      <= '0;
         src1_shamt_q <= 1'b0;
         src2_imm_q   <= 1'b0;
         rd_addr_q    <= '0;
         reg_write_q  <= 1'b0;
      end else if (stall) begin
         // Absorb writes retiring while held so they are not lost once the bypass moves on.
         rs_data_q <= fwd_rs;
         rt_data_q <= fwd_rt;
      end else begin
         valid_q      <= id_valid;
         alu_ctrl_q   <= id_alu_ctrl;
         sign_q       <= id_sign;
         rs_addr_q    <= id_rs_addr;
         rt_addr_q    <= id_rt_addr;
         rs_data_q    <= id_rs_data;
         rt_data_q    <= id_rt_data;
         imm_q        <= id_imm;
         shamt_q      <= id_shamt;
         src1_shamt_q <= id_src1_shamt;
         src2_imm_q   <= id_src2_imm;
         rd_addr_q    <= id_rd_addr;
         reg_write_q  <= id_reg_write;
      end
   end

   assign ex_valid      = valid_q;
   assign ex_alu_ctrl   = alu_ctrl_q;
   assign ex_sign       = sign_q;
   assign ex_in1        = src1_shamt_q ? DATA_W'(shamt_q) : fwd_rs;
   assign ex_in2        = src2_imm_q ? imm_q : fwd_rt;
   assign ex_store_data = fwd_rt;
   assign ex_rd_addr    = rd_addr_q;
   assign ex_reg_write  = reg_write_q & valid_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: directed vector table, reset corner cases, randomized model check.
module tb_ex_operand_stage;
   import cpu_pkg::*;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 5;
   localparam int unsigned CW = 5;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          stall, flush, id_valid, id_sign, id_src1_shamt, id_src2_imm, id_reg_write;
   logic [CW-1:0] id_alu_ctrl;
   logic [AW-1:0] id_rs_addr, id_rt_addr, id_rd_addr, mem_waddr, wb_waddr;
   logic [DW-1:0] id_rs_data, id_rt_data, id_imm, mem_wdata, wb_wdata;
   logic [4:0]    id_shamt;
   logic          mem_we, wb_we;
   logic          ex_valid, ex_sign, ex_reg_write;
   logic [CW-1:0] ex_alu_ctrl;
   logic [DW-1:0] ex_in1, ex_in2, ex_store_data;
   logic [AW-1:0] ex_rd_addr;

   ex_operand_stage #(.DATA_W(DW), .RADDR_W(AW), .CTRL_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
      .id_valid(id_valid), .id_alu_ctrl(id_alu_ctrl), .id_sign(id_sign),
      .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
      .id_shamt(id_shamt), .id_src1_shamt(id_src1_shamt), .id_src2_imm(id_src2_imm),
      .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write),
      .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
      .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
      .ex_valid(ex_valid), .ex_alu_ctrl(ex_alu_ctrl), .ex_sign(ex_sign),
      .ex_in1(ex_in1), .ex_in2(ex_in2), .ex_store_data(ex_store_data),
      .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic [31:0] ce, st, fl, vld, ctrl, rs, rsd, rt, rtd, imm, sh, s1, s2, rd, rw;
      logic [31:0] mwe, mwa, mwd, wwe, wwa, wwd;
      logic [31:0] ev, ectrl, erw, ein1, ein2, est;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(
      input logic [31:0] ce, st, fl, vld, ctrl, rs, rsd, rt, rtd, imm, sh, s1, s2, rd, rw,
      input logic [31:0] mwe, mwa, mwd, wwe, wwa, wwd,
      input logic [31:0] ev, ectrl, erw, ein1, ein2, est);
      vec_t v;
      v.ce = ce; v.st = st; v.fl = fl; v.vld = vld; v.ctrl = ctrl; v.rs = rs; v.rsd = rsd;
      v.rt = rt; v.rtd = rtd; v.imm = imm; v.sh = sh; v.s1 = s1; v.s2 = s2; v.rd = rd;
      v.rw = rw; v.mwe = mwe; v.mwa = mwa; v.mwd = mwd; v.wwe = wwe; v.wwa = wwa; v.wwd = wwd;
      v.ev = ev; v.ectrl = ectrl; v.erw = erw; v.ein1 = ein1; v.ein2 = ein2; v.est = est;
      return v;
   endfunction

   task automatic drive_idle();
      stall = 0; flush = 0; id_valid = 0; id_alu_ctrl = '0; id_sign = 0;
      id_rs_addr = '0; id_rt_addr = '0; id_rs_data = '0; id_rt_data = '0; id_imm = '0;
      id_shamt = '0; id_src1_shamt = 0; id_src2_imm = 0; id_rd_addr = '0; id_reg_write = 0;
      mem_we = 0; mem_waddr = '0; mem_wdata = '0; wb_we = 0; wb_waddr = '0; wb_wdata = '0;
   endtask

   task automatic apply_row(input int idx, input vec_t v);
      stall = v.st[0]; flush = v.fl[0]; id_valid = v.vld[0]; id_alu_ctrl = CW'(v.ctrl);
      id_sign = 1'b0; id_rs_addr = AW'(v.rs); id_rs_data = v.rsd; id_rt_addr = AW'(v.rt);
      id_rt_data = v.rtd; id_imm = v.imm; id_shamt = 5'(v.sh); id_src1_shamt = v.s1[0];
      id_src2_imm = v.s2[0]; id_rd_addr = AW'(v.rd); id_reg_write = v.rw[0];
      mem_we = v.mwe[0]; mem_waddr = AW'(v.mwa); mem_wdata = v.mwd;
      wb_we = v.wwe[0]; wb_waddr = AW'(v.wwa); wb_wdata = v.wwd;
      if (v.ce[0]) begin
         @(posedge clk);
         #1;
      end else begin
         #1;
      end
      check($sformatf("row%0d valid", idx), 32'(ex_valid), v.ev);
      check($sformatf("row%0d alu_ctrl", idx), 32'(ex_alu_ctrl), v.ectrl);
      check($sformatf("row%0d reg_write", idx), 32'(ex_reg_write), v.erw);
      check($sformatf("row%0d in1", idx), ex_in1, v.ein1);
      check($sformatf("row%0d in2", idx), ex_in2, v.ein2);
      check($sformatf("row%0d store_data", idx), ex_store_data, v.est);
   endtask

   // ---------------- behavioural reference model ----------------
   typedef struct packed {
      logic        valid;
      logic [4:0]  ctrl;
      logic        sign;
      logic [4:0]  rs_a, rt_a, rd;
      logic [31:0] rs_d, rt_d, imm;
      logic [4:0]  shamt;
      logic        s1, s2, rw;
   } mdl_t;

   mdl_t m;

   // Value a reader of register a would see now: youngest pending write wins, r0 stays put.
   function automatic logic [31:0] mfwd(input logic [4:0] a, input logic [31:0] stored);
      if (a == 0) return stored;
      if (mem_we && mem_waddr == a) return mem_wdata;
      if (wb_we && wb_waddr == a) return wb_wdata;
      return stored;
   endfunction

   task automatic model_edge();
      if (flush) begin
         m = '0;
      end else if (stall) begin
         m.rs_d = mfwd(m.rs_a, m.rs_d);
         m.rt_d = mfwd(m.rt_a, m.rt_d);
      end else begin
         m.valid = id_valid; m.ctrl = id_alu_ctrl; m.sign = id_sign;
         m.rs_a = id_rs_addr; m.rt_a = id_rt_addr; m.rd = id_rd_addr;
         m.rs_d = id_rs_data; m.rt_d = id_rt_data; m.imm = id_imm; m.shamt = id_shamt;
         m.s1 = id_src1_shamt; m.s2 = id_src2_imm; m.rw = id_reg_write;
      end
   endtask

   task automatic check_model(input int it);
      logic [31:0] e1, e2, est;
      est = mfwd(m.rt_a, m.rt_d);
      e1  = m.s1 ? 32'(m.shamt) : mfwd(m.rs_a, m.rs_d);
      e2  = m.s2 ? m.imm : est;
      check($sformatf("rnd%0d valid", it), 32'(ex_valid), 32'(m.valid));
      check($sformatf("rnd%0d alu_ctrl", it), 32'(ex_alu_ctrl), 32'(m.ctrl));
      check($sformatf("rnd%0d sign", it), 32'(ex_sign), 32'(m.sign));
      check($sformatf("rnd%0d rd_addr", it), 32'(ex_rd_addr), 32'(m.rd));
      check($sformatf("rnd%0d reg_write", it), 32'(ex_reg_write), 32'(m.rw && m.valid));
      check($sformatf("rnd%0d in1", it), ex_in1, e1);
      check($sformatf("rnd%0d in2", it), ex_in2, e2);
      check($sformatf("rnd%0d store_data", it), ex_store_data, est);
   endtask

   initial begin
      drive_idle();
      // Reset with busy ID inputs: outputs must be the bubble, before and across clock edges.
      id_valid = 1; id_alu_ctrl = ALU_SLT; id_rs_addr = 5'd1; id_rs_data = 32'h5;
      id_rt_addr = 5'd2; id_rt_data = 32'h7; id_reg_write = 1; id_rd_addr = 5'd3;
      #1;
      check("reset_async valid", 32'(ex_valid), 0);
      check("reset_async in1", ex_in1, 0);
      repeat (2) @(posedge clk);
      #1;
      check("reset valid", 32'(ex_valid), 0);
      check("reset alu_ctrl", 32'(ex_alu_ctrl), 32'(ALU_ADD));
      check("reset reg_write", 32'(ex_reg_write), 0);
      check("reset in1", ex_in1, 0);
      check("reset in2", ex_in2, 0);
      rst_n = 1;

      tbl.push_back(mk(1,0,0, 1,ALU_ADD, 1,5, 2,7, 0,0,0,0, 3,1, 0,0,0, 0,0,0,
                       1,ALU_ADD,1, 5,7,7));
      tbl.push_back(mk(1,0,0, 1,ALU_SUB, 3,'h11, 4,'h22, 0,0,0,0, 5,1, 0,0,0, 0,0,0,
                       1,ALU_SUB,1, 'h11,'h22,'h22));
      tbl.push_back(mk(0,0,0, 1,ALU_SUB, 3,'h11, 4,'h22, 0,0,0,0, 5,1, 1,3,'hAA, 1,3,'hBB,
                       1,ALU_SUB,1, 'hAA,'h22,'h22));
      tbl.push_back(mk(0,0,0, 1,ALU_SUB, 3,'h11, 4,'h22, 0,0,0,0, 5,1, 0,3,'hAA, 1,3,'hBB,
                       1,ALU_SUB,1, 'hBB,'h22,'h22));
      tbl.push_back(mk(1,0,0, 1,ALU_ADD, 0,0, 0,0, 0,0,0,0, 7,1, 1,0,'hFFFF, 0,0,0,
                       1,ALU_ADD,1, 0,0,0));
      tbl.push_back(mk(1,0,0, 1,ALU_AND, 1,'h10, 2,'h20, 0,0,0,0, 6,1, 0,0,0, 0,0,0,
                       1,ALU_AND,1, 'h10,'h20,'h20));
      tbl.push_back(mk(1,1,0, 1,ALU_OR, 7,'h99, 8,'h98, 0,0,0,0, 9,0, 0,0,0, 1,2,'h55,
                       1,ALU_AND,1, 'h10,'h55,'h55));
      tbl.push_back(mk(1,1,0, 1,ALU_OR, 7,'h99, 8,'h98, 0,0,0,0, 9,0, 0,0,0, 0,0,0,
                       1,ALU_AND,1, 'h10,'h55,'h55));
      tbl.push_back(mk(0,0,0, 1,ALU_OR, 7,'h99, 8,'h98, 0,0,0,0, 9,0, 0,0,0, 0,0,0,
                       1,ALU_AND,1, 'h10,'h55,'h55));
      tbl.push_back(mk(1,0,0, 1,ALU_OR, 7,'h99, 8,'h98, 0,0,0,0, 9,0, 0,0,0, 0,0,0,
                       1,ALU_OR,0, 'h99,'h98,'h98));
      tbl.push_back(mk(1,1,1, 1,ALU_XOR, 1,3, 2,4, 0,0,0,0, 4,1, 0,0,0, 0,0,0,
                       0,ALU_ADD,0, 0,0,0));
      tbl.push_back(mk(1,0,0, 1,ALU_SLL, 9,'h1234, 5,1, 0,4,1,0, 8,1, 0,0,0, 0,0,0,
                       1,ALU_SLL,1, 4,1,1));
      tbl.push_back(mk(1,0,0, 1,ALU_SLL, 9,'h1234, 5,1, 'hFFFFFFF0,4,1,1, 8,1, 0,0,0, 0,0,0,
                       1,ALU_SLL,1, 4,'hFFFFFFF0,1));
      tbl.push_back(mk(1,0,1, 1,ALU_SLT, 1,3, 2,4, 0,0,0,0, 4,1, 0,0,0, 0,0,0,
                       0,ALU_ADD,0, 0,0,0));

      @(posedge clk);
      #1;
      foreach (tbl[i]) apply_row(i, tbl[i]);

      // Reset asserted mid-stall/flush with a live instruction: reset wins, immediately.
      drive_idle();
      id_valid = 1; id_alu_ctrl = ALU_NOR; id_rs_addr = 5'd4; id_rs_data = 32'h1;
      id_reg_write = 1;
      @(posedge clk);
      #1;
      check("midrst pre valid", 32'(ex_valid), 1);
      stall = 1; flush = 1;
      rst_n = 0;
      #1;
      check("midrst valid", 32'(ex_valid), 0);
      check("midrst alu_ctrl", 32'(ex_alu_ctrl), 32'(ALU_ADD));
      check("midrst reg_write", 32'(ex_reg_write), 0);
      check("midrst in1", ex_in1, 0);
      @(posedge clk);
      #1;
      rst_n = 1;
      drive_idle();

      // Randomized run against the reference model.
      m = '0;
      @(posedge clk);
      #1;
      rst_n = 0;
      #1;
      rst_n = 1;
      for (int it = 0; it < 400; it++) begin
         stall = ($urandom_range(0, 3) == 0);
         flush = ($urandom_range(0, 9) == 0);
         id_valid = 1'($urandom_range(0, 1));
         id_alu_ctrl = 5'($urandom_range(0, 9));
         id_sign = 1'($urandom_range(0, 1));
         id_rs_addr = 5'($urandom_range(0, 3));
         id_rt_addr = 5'($urandom_range(0, 3));
         id_rs_data = $urandom;
         id_rt_data = $urandom;
         id_imm = $urandom;
         id_shamt = 5'($urandom);
         id_src1_shamt = ($urandom_range(0, 3) == 0);
         id_src2_imm = ($urandom_range(0, 3) == 0);
         id_rd_addr = 5'($urandom_range(0, 31));
         id_reg_write = 1'($urandom_range(0, 1));
         mem_we = 1'($urandom_range(0, 1));
         mem_waddr = 5'($urandom_range(0, 3));
         mem_wdata = $urandom;
         wb_we = 1'($urandom_range(0, 1));
         wb_waddr = 5'($urandom_range(0, 3));
         wb_wdata = $urandom;
         #1;
         check_model(it);
         if ($urandom_range(0, 49) == 0) begin
            rst_n = 0;
            #1;
            m = '0;
            check_model(it);
            rst_n = 1;
         end
         model_edge();
         @(posedge clk);
         #1;
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
